ysyx_22040750_clint_mh: RTL and testbench
=========================================

Name: ysyx_22040750_clint_mh

Overview:
- Multi-hart core-local interruptor; parametrised successor of the single-hart CLINT.
- One shared 64-bit mtime; per-hart mtimecmp and msip registers.
- Level timer and software interrupt outputs per hart.
- Sits on the uncached MMIO path as a full AXI4-lite slave: independent AW/W capture, registered R/B channels with backpressure, error responses for unmapped addresses.

Parameters:
- NHART, 2, number of harts (1..16); sizes the msip/mtimecmp arrays and the interrupt vectors.
- BASE_ADDR, 32'h0200_0000, CLINT base address.
- TICKCNT, 16, clock cycles per mtime increment (>=1).
- TICK_W, 12, prescaler counter width; requires TICKCNT <= 2^TICK_W.

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- O_mtip  out  NHART  timer interrupt per hart
- O_msip  out  NHART  software interrupt per hart
- I_clint_araddr  in  32  read address
- I_clint_arvalid  in  1  read address valid
- O_clint_arready  out  1  read address ready
- O_clint_rdata  out  64  read data
- O_clint_rresp  out  2  read response
- O_clint_rvalid  out  1  read data valid
- I_clint_rready  in  1  read data ready
- I_clint_awaddr  in  32  write address
- I_clint_awvalid  in  1  write address valid
- O_clint_awready  out  1  write address ready
- I_clint_wdata  in  64  write data
- I_clint_wstrb  in  8  byte strobes
- I_clint_wvalid  in  1  write data valid
- O_clint_wready  out  1  write data ready
- O_clint_bresp  out  2  write response
- O_clint_bvalid  out  1  write response valid
- I_clint_bready  in  1  write response ready

Behaviour:
- Reset (async assert, sync release):
  - mtime=0, prescaler=0, msip=0.
  - mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF, so no mtip after reset.
  - All valids 0, rdata=0, resp=0, AW/W latches empty.
- Address map (64-bit data bus; lane = addr[2]):
  - msip[h] at BASE+4h: bit0 only, other bits read 0.
  - mtimecmp[h] at BASE+0x4000+8h.
  - mtime at BASE+0xBFF8.
  - Any other address (including hart index >= NHART): resp 2'b11 DECERR, read data 0, write ignored.
- Prescaler counts 0..TICKCNT-1 then wraps to 0. mtime increments by 1 on the wrap cycle. TICKCNT=1 increments every cycle. mtime wraps from 2^64-1 to 0.
- O_mtip[h] = (mtime >= mtimecmp[h]), unsigned, driven from registers (combinational compare, no extra latency).
- O_msip[h] = msip[h] bit0.
- Read channel:
  - O_clint_arready = !O_clint_rvalid.
  - On AR handshake: rdata/rresp registered, rvalid=1 next cycle.
  - rvalid, rdata and rresp held stable until the R handshake.
  - Read data is the register value at the AR handshake edge.
- Write channel:
  - AW and W captured independently, in either order or the same cycle.
  - awready=0 while AW latched or bvalid=1; wready=0 while W latched or bvalid=1.
  - Commit happens on the edge after both are latched; bvalid rises at that edge and holds until bready. Latches clear at commit.
  - Byte-wise strobe merge: reg = (reg & ~mask) | (wdata & mask).
  - 32-bit msip uses strobe lane 0..3 or 4..7 per addr[2].
- Simultaneous events:
  - mtime write commit and tick in the same cycle: written value wins, increment lost, prescaler keeps counting.
  - Reads and writes are independent. A read accepted on the commit edge returns the pre-write value.
- Reset mid-transaction drops all pending AW/W/R/B state; no commit occurs.

Optional Feature:
- Macro: CLINT_RTC_TICK_EN.
- Defined:
  - Adds input I_rtc_tick (1 bit, asynchronous).
  - Passed through a 2-flop synchroniser plus rising-edge detect.
  - Each detected edge increments mtime. Prescaler and TICKCNT are unused.
  - Latency from I_rtc_tick rise to mtime update: 3 cycles.
- Undefined: port absent; the internal prescaler drives increments as above.

Test Plan:
- Reset, idle 3*TICKCNT cycles, then read mtime -> 3 (±1 per read latency). O_mtip=0, O_msip=0, rresp=00.
- Write mtimecmp[1]=0x20 (wstrb=FF), wait until mtime>=0x20 -> O_mtip=2'b10. Then write mtimecmp[1]=all ones -> O_mtip=0 on the cycle after commit.
- Write to msip[1] (BASE+4, lane 4..7) with W sent 3 cycles before AW -> one bvalid, bresp=00, O_msip=2'b10.
- Read BASE+0x10 (hart 4 >= NHART) with rready held low 5 cycles -> rvalid held, rdata=0, rresp=11, arready=0 throughout.
- Write mtime=0xFFFF_FFFF_FFFF_FFFF on the prescaler wrap cycle -> mtime reads all ones, then 0 after the next TICKCNT cycles.
- Assert I_rst_n=0 with AW latched and W pending, release -> no commit, bvalid=0, all registers at reset values.

Source files
------------

// File: rtl/ysyx_22040750_clint_mh.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp/msip, AXI4-lite slave.
// Optional CLINT_RTC_TICK_EN: mtime advanced by synchronised I_rtc_tick edges.
module ysyx_22040750_clint_mh #(
  parameter int          NHART     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICKCNT   = 16,
  parameter int          TICK_W    = 12
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
`ifdef CLINT_RTC_TICK_EN
  input  logic             I_rtc_tick,
`endif
  output logic [NHART-1:0] O_mtip,
  output logic [NHART-1:0] O_msip,
  input  logic [31:0]      I_clint_araddr,
  input  logic             I_clint_arvalid,
  output logic             O_clint_arready,
  output logic [63:0]      O_clint_rdata,
  output logic [1:0]       O_clint_rresp,
  output logic             O_clint_rvalid,
  input  logic             I_clint_rready,
  input  logic [31:0]      I_clint_awaddr,
  input  logic             I_clint_awvalid,
  output logic             O_clint_awready,
  input  logic [63:0]      I_clint_wdata,
  input  logic [7:0]       I_clint_wstrb,
  input  logic             I_clint_wvalid,
  output logic             O_clint_wready,
  output logic [1:0]       O_clint_bresp,
  output logic             O_clint_bvalid,
  input  logic             I_clint_bready
);

  localparam logic [1:0] K_ERR   = 2'd0;
  localparam logic [1:0] K_MSIP  = 2'd1;
  localparam logic [1:0] K_CMP   = 2'd2;
  localparam logic [1:0] K_MTIME = 2'd3;

  // returns {kind, hart index}
  function automatic logic [5:0] dec(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    dec = 6'd0;
    if (off < 32'(4*NHART) && off[1:0] == 2'b00)
      dec = {K_MSIP, off[5:2]};
    else if (off >= 32'h4000 &&
             off < 32'h4000 + 32'(8*NHART) &&
             off[2:0] == 3'b000)
      dec = {K_CMP, off[6:3]};
    else if (off == 32'h0000_BFF8)
      dec = {K_MTIME, 4'd0};
  endfunction

  logic [63:0]      mtime;
  logic [63:0]      mtimecmp [NHART];
  logic [NHART-1:0] msip;
  logic             tick;

  logic        aw_full, w_full;
  logic [31:0] aw_addr;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        commit;
  logic [5:0]  wdec;
  logic [1:0]  wkind;
  logic [3:0]  widx;
  logic [63:0] wmask;
  logic        ms_stb, ms_dat;

  logic [5:0]  rdec;
  logic [63:0] rd_data;
  logic [1:0]  rd_resp;

`ifdef CLINT_RTC_TICK_EN
  logic [2:0] rtc_q;

  // two-flop synchroniser plus delayed copy for edge detect
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) rtc_q <= '0;
    else          rtc_q <= {rtc_q[1:0], I_rtc_tick};
  end

  assign tick = rtc_q[1] & ~rtc_q[2];
`else
  localparam logic [TICK_W-1:0] PRE_MAX = TICK_W'(TICKCNT - 1);
  logic [TICK_W-1:0] pre;

  assign tick = (pre == PRE_MAX);

  // prescaler 0..TICKCNT-1, wraps on tick
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end
`endif

  assign commit = aw_full & w_full;
  assign wdec   = dec(aw_addr);
  assign wkind  = wdec[5:4];
  assign widx   = wdec[3:0];
  assign ms_stb = aw_addr[2] ? w_strb[4] : w_strb[0];
  assign ms_dat = aw_addr[2] ? w_data[32] : w_data[0];

  // expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++)
      wmask[8*i +: 8] = {8{w_strb[i]}};
  end

  // mtime: a committed write overrides the tick
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      mtime <= '0;
    else if (commit && wkind == K_MTIME)
      mtime <= (mtime & ~wmask) | (w_data & wmask);
    else if (tick)
      mtime <= mtime + 64'd1;
  end

  // per-hart msip and mtimecmp registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      msip <= '0;
      for (int h = 0; h < NHART; h++)
        mtimecmp[h] <= '1;
    end else if (commit) begin
      for (int h = 0; h < NHART; h++) begin
        if (wkind == K_MSIP && widx == 4'(h) && ms_stb)
          msip[h] <= ms_dat;
        if (wkind == K_CMP && widx == 4'(h))
          mtimecmp[h] <= (mtimecmp[h] & ~wmask)
                       | (w_data & wmask);
      end
    end
  end

  // interrupt outputs straight from the registers
  always_comb begin
    O_mtip = '0;
    for (int h = 0; h < NHART; h++)
      O_mtip[h] = (mtime >= mtimecmp[h]);
  end

  assign O_msip = msip;

  assign O_clint_awready = ~aw_full & ~O_clint_bvalid;
  assign O_clint_wready  = ~w_full & ~O_clint_bvalid;

  // independent AW/W capture, commit once both held
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      aw_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      O_clint_bvalid <= 1'b0;
      O_clint_bresp  <= 2'b00;
    end else if (commit) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      O_clint_bvalid <= 1'b1;
      O_clint_bresp  <= (wkind == K_ERR) ? 2'b11 : 2'b00;
    end else begin
      if (I_clint_awvalid && O_clint_awready) begin
        aw_full <= 1'b1;
        aw_addr <= I_clint_awaddr;
      end
      if (I_clint_wvalid && O_clint_wready) begin
        w_full <= 1'b1;
        w_data <= I_clint_wdata;
        w_strb <= I_clint_wstrb;
      end
      if (O_clint_bvalid && I_clint_bready)
        O_clint_bvalid <= 1'b0;
    end
  end

  assign rdec = dec(I_clint_araddr);

  // read mux on the incoming AR address
  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    unique case (rdec[5:4])
      K_MSIP: begin
        for (int h = 0; h < NHART; h++)
          if (rdec[3:0] == 4'(h))
            rd_data = I_clint_araddr[2]
                    ? {31'd0, msip[h], 32'd0}
                    : {63'd0, msip[h]};
      end
      K_CMP: begin
        for (int h = 0; h < NHART; h++)
          if (rdec[3:0] == 4'(h))
            rd_data = mtimecmp[h];
      end
      K_MTIME: rd_data = mtime;
      default: rd_resp = 2'b11;
    endcase
  end

  assign O_clint_arready = ~O_clint_rvalid;

  // registered R channel, held until handshake
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_clint_rvalid <= 1'b0;
      O_clint_rdata  <= '0;
      O_clint_rresp  <= 2'b00;
    end else if (I_clint_arvalid && O_clint_arready) begin
      O_clint_rvalid <= 1'b1;
      O_clint_rdata  <= rd_data;
      O_clint_rresp  <= rd_resp;
    end else if (O_clint_rvalid && I_clint_rready) begin
      O_clint_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_clint_mh.sv
// Scoreboard bench for ysyx_22040750_clint_mh.
// NHART=2, TICKCNT=4; directed vectors.
module tb_ysyx_22040750_clint_mh;

  localparam int          NH   = 2;
  localparam int          TC   = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NH-1:0] mtip, msip;
  logic [31:0]   araddr, awaddr;
  logic          arvalid, arready, rvalid, rready;
  logic [63:0]   rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wvalid, wready;
  logic [7:0]    wstrb;
  logic          bvalid, bready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];

  ysyx_22040750_clint_mh #(
    .NHART(NH), .BASE_ADDR(BASE), .TICKCNT(TC), .TICK_W(12)
  ) dut (
    .I_clk(clk),
    .I_rst_n(rst_n),
    .O_mtip(mtip),
    .O_msip(msip),
    .I_clint_araddr(araddr),
    .I_clint_arvalid(arvalid),
    .O_clint_arready(arready),
    .O_clint_rdata(rdata),
    .O_clint_rresp(rresp),
    .O_clint_rvalid(rvalid),
    .I_clint_rready(rready),
    .I_clint_awaddr(awaddr),
    .I_clint_awvalid(awvalid),
    .O_clint_awready(awready),
    .I_clint_wdata(wdata),
    .I_clint_wstrb(wstrb),
    .I_clint_wvalid(wvalid),
    .O_clint_wready(wready),
    .O_clint_bresp(bresp),
    .O_clint_bvalid(bvalid),
    .I_clint_bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: handshake at the coming posedge
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) begin
        chk("stray_r", 64'(rvalid), 64'd0);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        chk("rdata", rdata, e.d);
        chk("rresp", 64'(rresp), 64'(e.r));
      end
    end
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) begin
        chk("stray_b", 64'(bvalid), 64'd0);
      end else begin
        logic [1:0] eb;
        eb = bq.pop_front();
        chk("bresp", 64'(bresp), 64'(eb));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a,
                         input logic [63:0] ed,
                         input logic [1:0]  er,
                         input int          hold);
    rexp_t e;
    int n;
    e.d = ed;
    e.r = er;
    rq.push_back(e);
    rready  = (hold == 0);
    araddr  = a;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_rvalid", 64'(rvalid), 64'd1);
      chk("hold_arready", 64'(arready), 64'd0);
      chk("hold_rdata", rdata, ed);
      chk("hold_rresp", 64'(rresp), 64'(er));
      step();
    end
    rready = 1'b1;
    n = 0;
    while (rvalid && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) chk("r_timeout", 64'(rvalid), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [63:0] d,
                          input logic [7:0]  s,
                          input logic [1:0]  er,
                          input int          lead);
    int n;
    bq.push_back(er);
    wdata = d;
    wstrb = s;
    awaddr = a;
    if (lead > 0) begin
      wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      chk("w_latched_wready", 64'(wready), 64'd0);
      chk("w_only_awready", 64'(awready), 64'd1);
      for (int i = 1; i < lead; i++) step();
      awvalid = 1'b1;
      step();
      awvalid = 1'b0;
    end else begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("b_timeout", 64'(bvalid), 64'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    step();
    step();
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_arready", 64'(arready), 64'd1);
    rst_n = 1'b1;

    // 3*TC ticks of idle -> mtime 3
    while (cyc < 3*TC) step();
    chk("idle_mtip", 64'(mtip), 64'd0);
    chk("idle_msip", 64'(msip), 64'd0);
    do_read(BASE + 32'hBFF8, 64'd3, 2'b00, 0);

    // timer interrupt on hart 1
    do_write(BASE + 32'h4008, 64'h20, 8'hFF, 2'b00, 0);
    do_read(BASE + 32'h4008, 64'h20, 2'b00, 0);
    chk("pre_mtip", 64'(mtip), 64'd0);
    n = 0;
    while (mtip == '0 && n < 400) begin
      step();
      n++;
    end
    chk("mtip_rise", 64'(mtip), 64'b10);
    chk("mtip_cycle", 64'(cyc), 64'(32*TC));
    do_write(BASE + 32'h4008, '1, 8'hFF, 2'b00, 0);
    chk("mtip_clear", 64'(mtip), 64'd0);

    // cmp reset value and partial strobe merge
    do_read(BASE + 32'h4000, '1, 2'b00, 0);
    do_write(BASE + 32'h4000, 64'h1111_2222_3333_4444,
             8'h0F, 2'b00, 0);
    do_read(BASE + 32'h4000, 64'hFFFF_FFFF_3333_4444,
            2'b00, 0);
    chk("merge_mtip", 64'(mtip), 64'd0);

    // msip[1], W three cycles ahead of AW
    do_write(BASE + 32'h4, 64'h1_0000_0000, 8'hF0, 2'b00, 3);
    chk("msip_set", 64'(msip), 64'b10);
    do_read(BASE + 32'h4, 64'h1_0000_0000, 2'b00, 0);
    do_read(BASE, 64'd0, 2'b00, 0);

    // unmapped hart / address
    do_read(BASE + 32'h10, 64'd0, 2'b11, 5);
    do_write(BASE + 32'h8000, 64'hFFFF, 8'hFF, 2'b11, 0);
    chk("decerr_msip", 64'(msip), 64'b10);

    // mtime write on the tick edge, then wrap
    while ((cyc + 2) % TC != 0) step();
    do_write(BASE + 32'hBFF8, '1, 8'hFF, 2'b00, 0);
    chk("ones_mtip", 64'(mtip), 64'b11);
    do_read(BASE + 32'hBFF8, '1, 2'b00, 0);
    for (int i = 0; i < TC; i++) step();
    do_read(BASE + 32'hBFF8, 64'd0, 2'b00, 0);
    chk("wrap_mtip", 64'(mtip), 64'd0);

    // reset with AW latched and W pending
    awaddr  = BASE;
    awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("aw_latched", 64'(awready), 64'd0);
    wdata  = 64'd1;
    wstrb  = 8'hFF;
    wvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    wvalid = 1'b0;
    step();
    rst_n = 1'b1;
    do_read(BASE + 32'hBFF8, 64'd0, 2'b00, 0);
    chk("rr_bvalid", 64'(bvalid), 64'd0);
    chk("rr_msip", 64'(msip), 64'd0);
    chk("rr_mtip", 64'(mtip), 64'd0);
    chk("rr_awready", 64'(awready), 64'd1);
    chk("rr_wready", 64'(wready), 64'd1);
    do_read(BASE + 32'h4008, '1, 2'b00, 0);
    do_read(BASE + 32'h4000, '1, 2'b00, 0);
    do_read(BASE, 64'd0, 2'b00, 0);
    step();
    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("bq_empty", 64'(bq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
